// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU arbiter: op encoding, FSM states and
// the per-op execution latency.
package alu_pkg;

    localparam int W_DEFAULT = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_MUL = 3'b010,
        ALU_LSR = 3'b011,
        ALU_AND = 3'b100
    } alu_op_t;

    typedef enum logic {
        ST_IDLE,
        ST_EXEC
    } arb_state_t;

    // MUL is a multicycle path; everything else settles in one cycle.
    function automatic int op_latency(input logic [2:0] op, input int mul_cycles);
        return (op == ALU_MUL) ? mul_cycles : 1;
    endfunction

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= ALU_AND);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin grant: search starts one past the last
// granted requester and wraps, producing a one-hot grant plus its index.
module rr_arbiter #(
    parameter int N   = 2,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_any
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!grant_any && req[idx]) begin
                grant_any     = 1'b1;
                grant[idx]    = 1'b1;
                grant_id      = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between N_REQ requesters: round-robin accept, hold the ALU
// inputs for the op's execution window, then pulse the result to the owner.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int W          = W_DEFAULT,
    parameter int MUL_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_opa,
    input  logic [N_REQ*W-1:0] req_opb,
    input  logic [N_REQ*3-1:0] req_op,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [W-1:0]       rsp_result,
    output logic [W-1:0]       alu_opa,
    output logic [W-1:0]       alu_opb,
    output logic [2:0]         alu_signal,
    input  logic [W-1:0]       alu_result
);

    localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [IDW-1:0] LAST_RESET = IDW'(N_REQ - 1);

    arb_state_t       state;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   owner;
    logic [CNT_W-1:0] cnt;

    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_id;
    logic             grant_any;
    logic             handshake;
    logic [W-1:0]     sel_opa;
    logic [W-1:0]     sel_opb;
    logic [2:0]       sel_op;

    rr_arbiter #(
        .N   (N_REQ),
        .IDW (IDW)
    ) u_rr (
        .req       (req_valid),
        .last      (last_grant),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    // Offer is only made while idle and out of reset, so ready never leaks
    // during reset or while the ALU is busy.
    assign req_ready = (rst_n && (state == ST_IDLE) && grant_any) ? grant : '0;
    assign handshake = |(req_valid & req_ready);

    assign sel_opa = req_opa[int'(grant_id)*W +: W];
    assign sel_opb = req_opb[int'(grant_id)*W +: W];
    assign sel_op  = req_op[int'(grant_id)*3 +: 3];

    // The alu_* registers double as the latched operands, so the ALU inputs
    // only move on a handshake edge and stay put through EXEC and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= LAST_RESET;
            owner      <= '0;
            cnt        <= '0;
            alu_opa    <= '0;
            alu_opb    <= '0;
            alu_signal <= 3'b000;
            rsp_valid  <= '0;
            rsp_result <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        alu_opa    <= sel_opa;
                        alu_opb    <= sel_opb;
                        alu_signal <= sel_op;
                        owner      <= grant_id;
                        last_grant <= grant_id;
                        cnt        <= CNT_W'(op_latency(sel_op, MUL_CYCLES) - 1);
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_result       <= op_is_legal(alu_signal) ? alu_result : '0;
                        rsp_valid[owner] <= 1'b1;
                        state            <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: stimulus pushes expected responses into a
// scoreboard, a negedge monitor pops and compares whenever a response is due.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N_REQ      = 2;
    localparam int W          = 32;
    localparam int MUL_CYCLES = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*W-1:0] req_opa;
    logic [N_REQ*W-1:0] req_opb;
    logic [N_REQ*3-1:0] req_op;
    logic [N_REQ-1:0]   rsp_valid;
    logic [W-1:0]       rsp_result;
    logic [W-1:0]       alu_opa;
    logic [W-1:0]       alu_opb;
    logic [2:0]         alu_signal;
    logic [W-1:0]       alu_result;

    int cyc = 0;
    int nCompared = 0;
    int nMismatched = 0;

    typedef struct {
        int         owner;
        logic [W-1:0] result;
        int         due;
    } exp_t;

    exp_t sbQueue[$];

    alu_arbiter #(
        .N_REQ      (N_REQ),
        .W          (W),
        .MUL_CYCLES (MUL_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opa    (req_opa),
        .req_opb    (req_opb),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .alu_opa    (alu_opa),
        .alu_opb    (alu_opb),
        .alu_signal (alu_signal),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Behavioural stand-in for the shared ALU; illegal selects return junk
    // so the arbiter's zeroing of illegal results is visible.
    always_comb begin
        case (alu_signal)
            3'b000:  alu_result = alu_opa + alu_opb;
            3'b001:  alu_result = alu_opa - alu_opb;
            3'b010:  alu_result = alu_opa * alu_opb;
            3'b011:  alu_result = alu_opa >> alu_opb[4:0];
            3'b100:  alu_result = alu_opa & alu_opb;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    function automatic logic [N_REQ-1:0] oneHot(input int id);
        return N_REQ'(1) << id;
    endfunction

    // Monitor: compares at the due cycle, flags any response nobody expects.
    always @(negedge clk) begin
        exp_t e;
        if (sbQueue.size() > 0 && sbQueue[0].due == cyc) begin
            e = sbQueue.pop_front();
            checkOutput("rsp_valid", W'(rsp_valid), W'(oneHot(e.owner)));
            checkOutput("rsp_result", rsp_result, e.result);
        end else if (rsp_valid != '0) begin
            checkOutput("rsp_unexpected", W'(rsp_valid), '0);
        end
    end

    task automatic setReq(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op);
        req_opa[id*W +: W] = a;
        req_opb[id*W +: W] = b;
        req_op[id*3 +: 3]  = op;
    endtask

    task automatic waitReady(input int id, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 16; t++) begin
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!ok) checkOutput("ready_timeout", W'(req_ready), W'(oneHot(id)));
    endtask

    task automatic doReset();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One op from one requester; inputs are scrambled after the handshake so
    // the ALU-side checks prove the operands were latched.
    task automatic applyStimulus(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op, input logic [W-1:0] expRes,
                                 input int lat);
        bit ok;
        @(negedge clk);
        setReq(id, a, b, op);
        req_valid[id] = 1'b1;
        #1;
        waitReady(id, ok);
        if (ok) begin
            checkOutput("ready_grant", W'(req_ready), W'(oneHot(id)));
            sbQueue.push_back('{id, expRes, cyc + lat + 1});
            @(posedge clk);
            #1;
            setReq(id, ~a, ~b, op);
            for (int k = 0; k < lat; k++) begin
                @(negedge clk);
                #1;
                checkOutput("exec_alu_opa", alu_opa, a);
                checkOutput("exec_alu_opb", alu_opb, b);
                checkOutput("exec_alu_signal", W'(alu_signal), W'(op));
                checkOutput("exec_ready_low", W'(req_ready), '0);
            end
        end
        req_valid[id] = 1'b0;
    endtask

    // Both requesters held valid; pattern holds the expected req_ready per
    // cycle (2 bits each, cycle 0 in the low bits).
    task automatic rrBurst(input logic [15:0] pattern, input int n,
                           input logic [W-1:0] res0, input logic [W-1:0] res1);
        logic [N_REQ-1:0] expReady;
        @(negedge clk);
        req_valid = '1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            expReady = pattern[i*2 +: 2];
            checkOutput("rr_ready", W'(req_ready), W'(expReady));
            if (expReady == 2'b01) sbQueue.push_back('{0, res0, cyc + 2});
            else if (expReady == 2'b10) sbQueue.push_back('{1, res1, cyc + 2});
        end
        req_valid = '0;
    endtask

    initial begin
        bit ok;
        rst_n     = 1'b0;
        req_valid = 2'b01;
        req_opa   = '0;
        req_opb   = '0;
        req_op    = '0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_ready", W'(req_ready), '0);
        checkOutput("reset_rsp_valid", W'(rsp_valid), '0);
        checkOutput("reset_rsp_result", rsp_result, '0);
        checkOutput("reset_alu_opa", alu_opa, '0);
        checkOutput("reset_alu_opb", alu_opb, '0);
        checkOutput("reset_alu_signal", W'(alu_signal), '0);
        req_valid = '0;
        @(negedge clk);
        #1 rst_n = 1'b1;

        applyStimulus(0, 32'd5, 32'd7, ALU_ADD, 32'd12, 1);
        applyStimulus(1, 32'd6, 32'd7, ALU_MUL, 32'd42, MUL_CYCLES);
        applyStimulus(0, 32'hFFFF_FFFF, 32'd1, 3'b111, 32'd0, 1);

        // Requester 0 pulses while requester 1's MUL is executing.
        @(negedge clk);
        setReq(1, 32'd3, 32'd4, ALU_MUL);
        req_valid[1] = 1'b1;
        #1;
        waitReady(1, ok);
        if (ok) sbQueue.push_back('{1, 32'd12, cyc + MUL_CYCLES + 1});
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        setReq(0, 32'd99, 32'd1, ALU_ADD);
        req_valid[0] = 1'b1;
        #1;
        checkOutput("busy_ready_a", W'(req_ready), '0);
        @(negedge clk);
        #1;
        checkOutput("busy_ready_b", W'(req_ready), '0);
        req_valid = '0;

        setReq(0, 32'd1, 32'd1, ALU_ADD);
        setReq(1, 32'd2, 32'd2, ALU_ADD);
        rrBurst(16'h0021, 4, 32'd2, 32'd4);

        doReset();
        setReq(0, 32'd10, 32'd3, ALU_SUB);
        setReq(1, 32'd10, 32'd3, ALU_SUB);
        rrBurst(16'h2121, 8, 32'd7, 32'd7);

        // Reset lands in the middle of a MUL execution window.
        @(negedge clk);
        setReq(1, 32'd9, 32'd9, ALU_MUL);
        req_valid[1] = 1'b1;
        #1;
        waitReady(1, ok);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        #1;
        checkOutput("mul_opa_before_reset", alu_opa, 32'd9);
        req_valid = 2'b11;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_alu_opa", alu_opa, '0);
        checkOutput("midreset_alu_opb", alu_opb, '0);
        checkOutput("midreset_alu_signal", W'(alu_signal), '0);
        checkOutput("midreset_rsp_valid", W'(rsp_valid), '0);
        checkOutput("midreset_rsp_result", rsp_result, '0);
        checkOutput("midreset_ready", W'(req_ready), '0);
        repeat (3) @(negedge clk);
        req_valid = '0;
        #1 rst_n = 1'b1;

        applyStimulus(1, 32'h0000_00F0, 32'h0000_003C, ALU_AND, 32'h0000_0030, 1);

        repeat (4) @(negedge clk);
        #1;
        checkOutput("sb_drained", W'(sbQueue.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer sharing the single ALU instance between N_REQ requesters (execute stage, address/loop unit, etc.). Accepts one operation at a time via valid/ready, holds the ALU operand and select inputs stable for the operation's execution window, and returns the registered result to the winning requester as a one-cycle response pulse. MUL is run as a multicycle path of MUL_CYCLES cycles; all other ops take one cycle.

## Interface
- N_REQ, 2: number of requesters (2..8).
- W, 32: operand/result width.
- MUL_CYCLES, 2: cycles the ALU inputs are held for MUL (1..8).

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester operation request.
- req_ready  out  N_REQ  per-requester accept; at most one bit high.
- req_opa  in  N_REQ*W  operand A, requester i at bits [i*W +: W].
- req_opb  in  N_REQ*W  operand B, same packing.
- req_op  in  N_REQ*3  ALU select, requester i at [i*3 +: 3].
- rsp_valid  out  N_REQ  one-cycle result pulse to requester i.
- rsp_result  out  W  result; valid when any rsp_valid bit is high.
- alu_opa, alu_opb  out  W  to ALU Opa/Opb.
- alu_signal  out  3  to ALU ALUSignal.
- alu_result  in  W  from ALU ALUResult.

## Operation
- Op encoding: 000 ADD, 001 SUB, 010 MUL, 011 LSR, 100 AND; 101–111 illegal.
- FSM states IDLE, EXEC. Reset state IDLE.
- IDLE: rr grant selects among req_valid bits starting at (last_grant+1) mod N_REQ; req_ready[g] = 1 for the grantee only, combinational from req_valid and pointer. Handshake = req_valid[g] & req_ready[g].
- On handshake: latch opa, opb, op, owner id into registers; last_grant <= g; cnt <= L-1 where L = MUL_CYCLES for MUL, else 1; go EXEC.
- EXEC: req_ready all 0. alu_* driven from latched registers only. If cnt != 0, decrement. If cnt == 0: rsp_result <= alu_result (or 0 for illegal op), rsp_valid[owner] <= 1 for one cycle, go IDLE.
- Responses have no backpressure; requester must sample on the pulse.
- Requester may drop req_valid before its handshake without effect. Requester keeping req_valid high across its own response competes normally in the next IDLE.
- Grant pointer advances only on handshake, never on a mere grant offer.

## Timing
- Reset values: req_ready 0 (in reset), rsp_valid 0, rsp_result 0, alu_opa/alu_opb 0, alu_signal 000, last_grant N_REQ-1 (requester 0 wins first), cnt 0.
- Handshake in cycle t → rsp_valid high in cycle t+L+1; L=1 non-MUL, MUL_CYCLES for MUL.
- rsp_valid cycle coincides with IDLE: a new handshake may occur in that same cycle. Sustained throughput one op per L+1 cycles.
- alu_opa/alu_opb/alu_signal change only at handshake edges; stable for the whole EXEC window (multicycle-path constraint relies on this). Held at last value while IDLE.
- Reset asserted mid-EXEC: operation discarded, no rsp_valid, all outputs to reset values asynchronously.
- Simultaneous requests: strict round robin; with all N_REQ requesting continuously each is served once per N_REQ ops.

## Structure
- Package alu_pkg: alu_op_t enum (ADD, SUB, MUL, LSR, AND), W default, op latency function, arbiter state enum.
- Sub-module rr_arbiter (combinational N-way round-robin grant from request vector and last-grant pointer, one-hot output). Remainder in alu_arbiter.

## Test plan
- Reset, then req 0 ADD 5+7 at t → req_ready[0] at t, rsp_valid[0] at t+2, rsp_result 12; ALU outputs 0 during reset.
- Req 1 MUL 6×7, MUL_CYCLES=2 → alu_* stable for 2 cycles, rsp_valid[1] at t+3, result 42; req_ready low throughout EXEC.
- Both requesters continuously issue SUB 10-3 → grants alternate 0,1,0,1 from reset; each rsp 7; one rsp every 2 cycles.
- Illegal op 111 with opa 0xFFFFFFFF → rsp after 1-cycle EXEC, rsp_result 0.
- rst_n low during MUL EXEC → no rsp_valid ever, outputs 0 immediately; post-reset req 1 ANDs 0xF0&0x3C → 0x30.
- req_valid[0] pulsed while EXEC busy then dropped → never accepted, no response, pointer unchanged.
